regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file for the RISC-V core, with a per-register busy scoreboard.
- Serves NRD decode-stage read ports and NWR writeback ports.
- Decode marks destination registers busy on issue; writeback clears them.
- Gives decode the operand data, write-through bypass and hazard status in a single cycle.

---
 rtl/regfile_mp_sb_pkg.sv | 16 +
 rtl/regfile_wr_match.sv | 26 ++
 rtl/regfile_mp_sb.sv | 97 +++++++++
 tb/tb_regfile_mp_sb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and helpers for the multi-port register file with busy scoreboard.
package regfile_mp_sb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam logic RST_ACTIVE = 1'b0;
  localparam int ZERO_ADDR = 0;

  function automatic int addr_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regfile_wr_match.sv
// Matches one lookup address against all write ports; the highest-index enabled port wins.
module regfile_wr_match #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [AW-1:0]       addr,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic                hit,
  output logic [XLEN-1:0]     data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k] && (wr_addr[k*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wr_data[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-through bypass and per-register busy scoreboard.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regs    [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_val  [NREGS];
  logic [NRD-1:0]   rd_hit;
  logic [XLEN-1:0]  rd_byp  [NRD];

  // One matcher per register resolves both the stored write and the busy clear.
  for (genvar r = 0; r < NREGS; r++) begin : g_reg_match
    regfile_wr_match #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_match (
      .addr    (AW'(r)),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (wr_hit[r]),
      .data    (wr_val[r])
    );
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd_match
    regfile_wr_match #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_match (
      .addr    (rd_addr[j*AW +: AW]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (rd_hit[j]),
      .data    (rd_byp[j])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit[r] && !(ZERO_REG != 0 && r == ZERO_ADDR)) regs[r] <= wr_val[r];
      end
    end
  end

  // Issue set beats flush and writeback clear, so a same-cycle issue always survives.
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < NREGS; r++) begin
      if (flush || wr_hit[r]) busy_nxt[r] = 1'b0;
      if (iss_en && (iss_addr == AW'(r))) busy_nxt[r] = 1'b1;
      if (ZERO_REG != 0 && r == ZERO_ADDR) busy_nxt[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) busy <= '0;
    else                   busy <= busy_nxt;
  end

  assign busy_vec = busy;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NRD; j++) begin
      if ((rst != RST_ACTIVE) && rd_en[j] &&
          !(ZERO_REG != 0 && int'(rd_addr[j*AW +: AW]) == ZERO_ADDR)) begin
        rd_data[j*XLEN +: XLEN] = rd_hit[j] ? rd_byp[j] : regs[rd_addr[j*AW +: AW]];
        rd_busy[j]              = busy[rd_addr[j*AW +: AW]] & ~rd_hit[j];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized and directed bench for regfile_mp_sb against an array-based reference model.
module tb_regfile_mp_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;

  always #5 clk = ~clk;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_busy [NREGS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int wa(input int k);
    return int'(wr_addr[k*AW +: AW]);
  endfunction

  function automatic int ra(input int j);
    return int'(rd_addr[j*AW +: AW]);
  endfunction

  // Expected read value: disabled/zero/reset give 0, newest same-cycle write wins, else stored.
  function automatic logic [XLEN-1:0] m_read(input int j);
    if (!rst || !rd_en[j] || ra(j) == 0) return '0;
    for (int k = NWR - 1; k >= 0; k--)
      if (wr_en[k] && wa(k) == ra(j)) return wr_data[k*XLEN +: XLEN];
    return m_reg[ra(j)];
  endfunction

  function automatic logic m_rbusy(input int j);
    if (!rst || !rd_en[j] || ra(j) == 0) return 1'b0;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && wa(k) == ra(j)) return 1'b0;
    return m_busy[ra(j)];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k] && wa(k) != 0) m_reg[wa(k)] = wr_data[k*XLEN +: XLEN];
      if (wr_en[k]) m_busy[wa(k)] = 1'b0;
    end
    if (flush) for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
    if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
  endtask

  task automatic look(input string tag);
    logic [NREGS-1:0] v;
    #1;
    if (!rst) model_reset();
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    for (int j = 0; j < NRD; j++) begin
      chk($sformatf("%s_rd%0d", tag, j), rd_data[j*XLEN +: XLEN], m_read(j));
      chk($sformatf("%s_bz%0d", tag, j), rd_busy[j], m_rbusy(j));
    end
    chk({tag, "_bvec"}, busy_vec, v);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic wr(input int k, input int a, input logic [XLEN-1:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int j, input int a);
    rd_en[j] = 1'b1;
    rd_addr[j*AW +: AW] = AW'(a);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset then read
    look("rst_a"); tick();
    look("rst_b"); tick();
    rst = 1'b1;
    rd(0, 3); rd(1, 5);
    look("t1");
    chk("t1_data", rd_data, 64'h0);
    chk("t1_busy", rd_busy, 2'b00);
    chk("t1_bvec", busy_vec, 32'h0);
    tick();

    // Bypass then stored value
    idle(); wr(0, 7, 32'hDEADBEEF); rd(0, 7);
    look("t2a");
    chk("t2_byp", rd_data[31:0], 32'hDEADBEEF);
    tick();
    idle(); rd(0, 7);
    look("t2b");
    chk("t2_store", rd_data[31:0], 32'hDEADBEEF);
    tick();

    // Same-address write conflict
    idle(); wr(0, 9, 32'h11); wr(1, 9, 32'h22); rd(0, 9);
    look("t3a");
    chk("t3_byp", rd_data[31:0], 32'h22);
    tick();
    idle(); rd(1, 9);
    look("t3b");
    chk("t3_store", rd_data[63:32], 32'h22);
    tick();

    // Scoreboard issue and writeback
    idle(); iss_en = 1'b1; iss_addr = 5'd4; rd(0, 4);
    look("t4a");
    chk("t4_nolook", rd_busy[0], 1'b0);
    tick();
    idle(); rd(0, 4);
    look("t4b");
    chk("t4_bvec", busy_vec[4], 1'b1);
    chk("t4_rbusy", rd_busy[0], 1'b1);
    tick();
    idle(); wr(1, 4, 32'h55); rd(0, 4);
    look("t4c");
    chk("t4_wb_busy", rd_busy[0], 1'b0);
    chk("t4_wb_data", rd_data[31:0], 32'h55);
    tick();
    idle();
    look("t4d");
    chk("t4_clr", busy_vec[4], 1'b0);
    tick();

    // Set/clear collision, then flush with surviving issue
    idle(); iss_en = 1'b1; iss_addr = 5'd6; wr(0, 6, 32'h66);
    look("t5a"); tick();
    idle(); iss_en = 1'b1; iss_addr = 5'd12;
    look("t5b");
    chk("t5_set_wins", busy_vec[6], 1'b1);
    tick();
    idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd12;
    look("t5c");
    chk("t5_pre", busy_vec, 32'h0000_1040);
    tick();
    idle();
    look("t5d");
    chk("t5_flush", busy_vec, 32'h0000_1000);
    tick();

    // Zero register
    idle(); wr(1, 0, 32'hFFFF); rd(0, 0);
    look("t6a");
    chk("t6_zero_byp", rd_data[31:0], 32'h0);
    tick();
    idle(); rd(0, 0); iss_en = 1'b1; iss_addr = 5'd0;
    look("t6b");
    chk("t6_zero_rd", rd_data[31:0], 32'h0);
    tick();
    idle();
    look("t6c");
    chk("t6_zero_bz", busy_vec[0], 1'b0);
    tick();
    idle(); wr(0, 3, 32'hABC);
    look("t6d"); tick();
    idle(); wr(0, 3, 32'h123); rst = 1'b0;
    look("t6e");
    chk("t6_rst_out", rd_data, 64'h0);
    tick();
    rst = 1'b1; idle(); rd(1, 3);
    look("t6f");
    chk("t6_rst_reg", rd_data[63:32], 32'h0);
    tick();

    // Random traffic with narrow address windows to provoke collisions
    for (int i = 0; i < 400; i++) begin
      int lim;
      idle();
      lim = ($urandom_range(0, 1) == 1) ? 7 : NREGS - 1;
      rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < NWR; k++)
        if ($urandom_range(0, 2) == 0) wr(k, $urandom_range(0, lim), $urandom);
      for (int j = 0; j < NRD; j++)
        if ($urandom_range(0, 3) != 0) rd(j, $urandom_range(0, lim));
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = AW'($urandom_range(0, lim));
      flush    = ($urandom_range(0, 15) == 0);
      look("rnd");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
